// File: rtl/apple1_bus_if.sv
// CPU-side bus of the Apple-1 fabric: address/data/strobe from the 6502, read data and ready back.
// Handshake: an access completes on the clk25 edge where cpu_clken & ready are both high;
// with ready low the CPU must hold ab/dbo/we stable, and a changed ab abandons the pending access.
interface apple1_bus_if;
    logic        cpu_clken;
    logic [15:0] ab;
    logic [7:0]  dbo;
    logic        we;
    logic [7:0]  dbi;
    logic        ready;

    modport master (output cpu_clken, ab, dbo, we, input dbi, ready);
    modport slave  (input cpu_clken, ab, dbo, we, output dbi, ready);
endinterface

// File: rtl/apple1_bus_ctrl.sv
// Apple-1 CPU bus fabric: address decode to NSLOT chip selects, read mux, per-slot
// wait states, a small control-register bank and an unmapped-write error log.
module apple1_bus_ctrl #(
    parameter int              NSLOT    = 8,
    parameter int              WAIT_W   = 3,
    parameter int              NREG     = 4,
    parameter logic [15:0]     REG_BASE = 16'hC000,
    parameter logic [NREG*8-1:0] REG_INIT = '0
) (
    input  logic                    clk25,
    input  logic                    rst,
    apple1_bus_if.slave             bus,
    input  logic [NSLOT*16-1:0]     slot_base,
    input  logic [NSLOT*16-1:0]     slot_mask,
    input  logic [NSLOT*WAIT_W-1:0] slot_wait,
    input  logic [NSLOT*8-1:0]      slot_dout,
    input  logic                    clr_err,
    output logic [NSLOT-1:0]        slot_cs,
    output logic [NSLOT-1:0]        slot_en,
    output logic                    slot_we,
    output logic [NREG*8-1:0]       reg_out,
    output logic                    bus_err,
    output logic [15:0]             err_addr,
    output logic                    dbg_state
);
    localparam int IDX_W  = $clog2(NREG);
    localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]         lat_ab_q, lat_ab_d;

    logic                reg_hit, slot_hit, slot_sel, unmapped;
    logic [SLOT_W-1:0]   sel;
    logic [WAIT_W-1:0]   w_sel;
    logic [IDX_W-1:0]    reg_idx;
    logic                done, xfer;

    assign reg_idx = bus.ab[IDX_W-1:0];

    // Decode: scan from the top so the lowest hitting slot index is the one kept.
    always_comb begin
        reg_hit  = (bus.ab[15:IDX_W] == REG_BASE[15:IDX_W]);
        slot_hit = 1'b0;
        sel      = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if ((bus.ab & slot_mask[i*16 +: 16]) == (slot_base[i*16 +: 16] & slot_mask[i*16 +: 16])) begin
                slot_hit = 1'b1;
                sel      = SLOT_W'(i);
            end
        end
        slot_sel = slot_hit & ~reg_hit;
        unmapped = ~reg_hit & ~slot_hit;
        slot_cs  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_cs[i] = slot_sel && (sel == SLOT_W'(i));
        end
        w_sel = slot_sel ? slot_wait[sel*WAIT_W +: WAIT_W] : '0;
        if (reg_hit)
            bus.dbi = reg_out[reg_idx*8 +: 8];
        else if (slot_hit)
            bus.dbi = slot_dout[sel*8 +: 8];
        else
            bus.dbi = 8'hFF;
    end

    // Wait-state FSM: an address change while waiting drops the access without completing it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_ab_d = lat_ab_q;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                done = (w_sel == '0);
                if (bus.cpu_clken && (w_sel != '0)) begin
                    state_d  = S_WAIT;
                    cnt_d    = w_sel - WAIT_W'(1);
                    lat_ab_d = bus.ab;
                end
            end
            S_WAIT: begin
                if (bus.ab != lat_ab_q) begin
                    state_d = S_IDLE;
                end else begin
                    done = (cnt_q == '0);
                    if (bus.cpu_clken) begin
                        if (cnt_q != '0) cnt_d   = cnt_q - WAIT_W'(1);
                        else             state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lat_ab_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_ab_q <= lat_ab_d;
        end
    end

    assign bus.ready = done & ~rst;
    assign xfer      = bus.cpu_clken & bus.ready;
    assign slot_en   = slot_cs & {NSLOT{xfer}};
    assign slot_we   = bus.we & (|slot_en);
    assign dbg_state = (state_q == S_WAIT);

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            reg_out <= REG_INIT;
        end else if (reg_hit && bus.we && xfer) begin
            reg_out[reg_idx*8 +: 8] <= bus.dbo;
        end
    end

    // A new error on the same edge as a clear re-arms the log with the new address.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (unmapped && bus.we && xfer) begin
            bus_err <= 1'b1;
            if (!bus_err || clr_err) err_addr <= bus.ab;
        end else if (clr_err) begin
            bus_err <= 1'b0;
        end
    end
endmodule
